// File: rtl/fp_div_pkg.sv
// Shared types and helpers for the iterative floating-point divider.
//   state_t     : controller states
//   op_class_t  : operand classification after subnormal flush
//   FLG_*       : bit positions inside the 5-bit {NV, DZ, OF, UF, NX} flag vector
//   classify()  : maps exponent/mantissa summary bits to an operand class. It takes
//                 summary bits rather than raw fields, so it works for any EXP_W/MAN_W.
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_RND,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } op_class_t;

    localparam int NUM_FLAGS = 5;
    localparam int FLG_NX    = 0;
    localparam int FLG_UF    = 1;
    localparam int FLG_OF    = 2;
    localparam int FLG_DZ    = 3;
    localparam int FLG_NV    = 4;

    // A zero exponent is treated as zero regardless of the mantissa,
    // so subnormal inputs are flushed to zero here.
    function automatic op_class_t classify(input logic exp_zero,
                                           input logic exp_ones,
                                           input logic man_zero);
        op_class_t cls;
        if (exp_ones)
            cls = man_zero ? CLS_INF : CLS_NAN;
        else if (exp_zero)
            cls = CLS_ZERO;
        else
            cls = CLS_NORM;
        return cls;
    endfunction

endpackage

// File: rtl/fp_div_round.sv
// Normalise, round-to-nearest-even and range-check a raw restoring-division quotient.
// Purely combinational; the parent registers the result.
//   quo    : {int, MAN_W fraction bits, guard, round}
//   sticky : final remainder was nonzero
//   e_in   : biased exponent before normalisation (signed)
//   man/exp/flags : final mantissa field, exponent field and {NV,DZ,OF,UF,NX}
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     [MAN_W+2:0]     quo,
    input  logic                                     sticky,
    input  logic signed              [EXP_W+1:0]     e_in,
    output logic                     [MAN_W-1:0]     man,
    output logic                     [EXP_W-1:0]     exp,
    output logic                     [NUM_FLAGS-1:0] flags
);

    localparam logic signed [EXP_W+1:0] ONE    = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;
    localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((2**EXP_W) - 1);

    logic                    norm;
    logic [MAN_W-1:0]        frac_raw;
    logic                    g;
    logic                    s;
    logic                    rnd_up;
    logic [MAN_W:0]          frac_sum;
    logic signed [EXP_W+1:0] e_norm;
    logic signed [EXP_W+1:0] e_rnd;

    // Quotient lies in (0.5, 2); a zero integer bit means shift left by one.
    // After that shift the round bit is gone, but the remainder still covers
    // everything below guard, so sticky alone is the correct OR-reduction.
    assign norm     = quo[MAN_W+2];
    assign frac_raw = norm ? quo[MAN_W+1:2] : quo[MAN_W:1];
    assign g        = norm ? quo[1] : quo[0];
    assign s        = norm ? (quo[0] | sticky) : sticky;
    assign e_norm   = norm ? e_in : e_in - ONE;

    assign rnd_up   = g & (s | frac_raw[0]);
    assign frac_sum = {1'b0, frac_raw} + {{MAN_W{1'b0}}, rnd_up};
    // A carry out means the significand became exactly 2.0: fraction wraps to 0.
    assign e_rnd    = frac_sum[MAN_W] ? e_norm + ONE : e_norm;

    always_comb begin
        man           = frac_sum[MAN_W-1:0];
        exp           = e_rnd[EXP_W-1:0];
        flags         = '0;
        flags[FLG_NX] = g | s;
        if (e_rnd >= E_MAX) begin
            man           = '0;
            exp           = '1;
            flags[FLG_OF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end else if (e_rnd <= E_ZERO) begin
            man           = '0;
            exp           = '0;
            flags[FLG_UF] = 1'b1;
            flags[FLG_NX] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative radix-2 floating-point divider with valid/ready handshakes.
// One quotient bit per cycle; special operands bypass the iteration.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for operands, in_ready = enable
//   ST_DIV   | restoring division, MAN_W+3 quotient bits, then sticky
//   ST_RND   | normalise/round/range-check, register result
//   ST_DONE  | result held with out_valid = 1 until popped
//
// Ports: clk, rstn (sync active-low), enable (global stall),
//        in_valid/in_ready + a_*/b_* operands,
//        out_valid/out_ready + r_man/r_exp/r_sign/r_flags result.
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MAN_W-1:0]     a_man,
    input  logic [EXP_W-1:0]     a_exp,
    input  logic                 a_sign,
    input  logic [MAN_W-1:0]     b_man,
    input  logic [EXP_W-1:0]     b_exp,
    input  logic                 b_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MAN_W-1:0]     r_man,
    output logic [EXP_W-1:0]     r_exp,
    output logic                 r_sign,
    output logic [NUM_FLAGS-1:0] r_flags
);

    localparam int                      CNT_W    = $clog2(MAN_W + 4);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(MAN_W + 2);
    localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W+2)'((2**(EXP_W-1)) - 1);
    localparam logic [MAN_W-1:0]        QNAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};

    state_t                  state;
    logic [MAN_W+1:0]        rem;
    logic [MAN_W:0]          dvs;
    logic [MAN_W+2:0]        quo;
    logic [CNT_W-1:0]        cnt;
    logic signed [EXP_W+1:0] e_acc;
    logic                    sgn;
    logic                    sticky;

    op_class_t               cls_a;
    op_class_t               cls_b;
    logic                    is_special;
    logic                    sp_sign;
    logic [EXP_W-1:0]        sp_exp;
    logic [MAN_W-1:0]        sp_man;
    logic [NUM_FLAGS-1:0]    sp_flags;

    logic                    q_bit;
    logic [MAN_W+1:0]        rem_sel;
    logic [MAN_W+1:0]        rem_nxt;

    logic [MAN_W-1:0]        rnd_man;
    logic [EXP_W-1:0]        rnd_exp;
    logic [NUM_FLAGS-1:0]    rnd_flags;

    assign in_ready = (state == ST_IDLE) & enable;

    assign cls_a = classify(a_exp == '0, &a_exp, a_man == '0);
    assign cls_b = classify(b_exp == '0, &b_exp, b_man == '0);

    always_comb begin
        is_special = 1'b1;
        sp_sign    = a_sign ^ b_sign;
        sp_exp     = '0;
        sp_man     = '0;
        sp_flags   = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF && cls_b == CLS_INF)) begin
            sp_sign          = 1'b0;
            sp_exp           = '1;
            sp_man           = QNAN_MAN;
            sp_flags[FLG_NV] = 1'b1;
        end else if (cls_a == CLS_INF) begin
            sp_exp = '1;
        end else if (cls_b == CLS_ZERO) begin
            sp_exp           = '1;
            sp_flags[FLG_DZ] = 1'b1;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            sp_exp = '0;
        end else begin
            is_special = 1'b0;
        end
    end

    // Partial remainder stays below 2*divisor, so MAN_W+2 bits never overflow.
    assign q_bit   = rem >= {1'b0, dvs};
    assign rem_sel = q_bit ? (rem - {1'b0, dvs}) : rem;
    assign rem_nxt = rem_sel << 1;

    fp_div_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .quo    (quo),
        .sticky (sticky),
        .e_in   (e_acc),
        .man    (rnd_man),
        .exp    (rnd_exp),
        .flags  (rnd_flags)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            rem       <= '0;
            dvs       <= '0;
            quo       <= '0;
            cnt       <= '0;
            e_acc     <= '0;
            sgn       <= 1'b0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            r_man     <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_flags   <= '0;
        end else if (enable) begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_special) begin
                            r_man     <= sp_man;
                            r_exp     <= sp_exp;
                            r_sign    <= sp_sign;
                            r_flags   <= sp_flags;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            rem    <= {2'b01, a_man};
                            dvs    <= {1'b1, b_man};
                            quo    <= '0;
                            cnt    <= '0;
                            sticky <= 1'b0;
                            sgn    <= a_sign ^ b_sign;
                            e_acc  <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
                            state  <= ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    rem <= rem_nxt;
                    quo <= {quo[MAN_W+1:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sticky <= rem_nxt != '0;
                        state  <= ST_RND;
                    end
                end
                ST_RND: begin
                    r_man     <= rnd_man;
                    r_exp     <= rnd_exp;
                    r_sign    <= sgn;
                    r_flags   <= rnd_flags;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
